controle_mc_param: RTL and testbench

//  Parametrised multicycle RV32I control FSM; successor to the fixed-latency controller.

---
 rtl/controle_pkg.sv | 65 ++++++
 rtl/ctrl_wait_timer.sv | 34 +++
 rtl/controle_mc_param.sv | 231 +++++++++++++++++++++++
 tb/tb_controle_mc_param.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_pkg.sv
// Shared encodings for the multicycle RV32I controller and its datapath muxes.
package controle_pkg;

    // RV32I major opcodes (iInst[6:0])
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    // ALU operand A select
    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcARegA  = 2'b01;
    localparam logic [1:0] SrcAOldPc = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SrcBRegB = 2'b00;
    localparam logic [1:0] SrcBFour = 2'b01;
    localparam logic [1:0] SrcBImm  = 2'b10;

    // Register write-back select
    localparam logic [1:0] MemtoRegAluOut = 2'b00;
    localparam logic [1:0] MemtoRegMdr    = 2'b01;
    localparam logic [1:0] MemtoRegLink   = 2'b10;
    localparam logic [1:0] MemtoRegImm    = 2'b11;

    // Next-PC select
    localparam logic [1:0] PcSrcAlu     = 2'b00;
    localparam logic [1:0] PcSrcAluOut  = 2'b01;
    localparam logic [1:0] PcSrcAluClr0 = 2'b10;

    // ALU control class
    localparam logic [1:0] AluOpAdd    = 2'b00;
    localparam logic [1:0] AluOpBranch = 2'b01;
    localparam logic [1:0] AluOpRFunct = 2'b10;
    localparam logic [1:0] AluOpIFunct = 2'b11;

    typedef enum logic [5:0] {
        StFetch,
        StDecode,
        StMemAddr,
        StLwRd,
        StLwWb,
        StSwWr,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StJal,
        StJalr,
        StLui,
        StAuipc,
        StTrap
    } ctrlStateT;

    // States that hold on a memory handshake and are guarded by the wait timer
    function automatic logic isWaitState(input ctrlStateT s);
        return (s == StFetch) || (s == StLwRd) || (s == StSwWr);
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Counts consecutive wait cycles of one memory access and flags the last allowed one.
module ctrl_wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iClear,
    input  logic iCountEn,
    output logic oExpired
);

    localparam int unsigned Width   = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam bit          Enabled = (LIMIT != 0);
    localparam logic [Width-1:0] LastWait = Width'(LIMIT - 1);

    logic [Width-1:0] countQ;

    // Wait-cycle counter; saturates so an unlimited wait never wraps
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            countQ <= '0;
        end else if (iClear) begin
            countQ <= '0;
        end else if (iCountEn && (countQ != '1)) begin
            countQ <= countQ + 1'b1;
        end
    end

    // This wait cycle would bring the count up to LIMIT
    always_comb begin
        oExpired = Enabled && iCountEn && (countQ == LastWait);
    end

endmodule

// File: rtl/controle_mc_param.sv
// Multicycle RV32I control FSM with memory handshake, access timeout and illegal-opcode trap.
module controle_mc_param
    import controle_pkg::*;
#(
    parameter int unsigned MEM_HANDSHAKE = 1,
    parameter int unsigned MEM_TIMEOUT   = 16,
    parameter int unsigned EN_UPPER      = 1
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [31:0] iInst,
    input  logic        iMemReady,
    output logic        oRegWrite,
    output logic [1:0]  oALUSrcA,
    output logic [1:0]  oALUSrcB,
    output logic        oMemRead,
    output logic        oMemWrite,
    output logic [1:0]  oMemtoReg,
    output logic        oIoD,
    output logic        oIRWrite,
    output logic        oPCWrite,
    output logic        oPCWriteCond,
    output logic [1:0]  oALUOp,
    output logic [1:0]  oPCSource,
    output logic        oIllegal,
    output logic        oMemFault,
    output logic        oRetire
);

    ctrlStateT   stateQ, stateD;
    logic        illegalQ, faultQ;
    logic        illegalSet, faultSet;
    logic        rdy, waiting, expired;
    logic [6:0]  opcode;
    logic        unusedInst;

    logic        regWrite, memRead, memWrite, ioD, irWrite, pcWrite, pcWriteCond, retire;
    logic [1:0]  aluSrcA, aluSrcB, memtoReg, aluOp, pcSource;

    assign opcode     = iInst[6:0];
    assign unusedInst = ^iInst[31:7];
    assign rdy        = (MEM_HANDSHAKE == 0) ? 1'b1 : iMemReady;

    // A memory state is stalling this cycle
    always_comb begin
        waiting = isWaitState(stateQ) && !rdy;
    end

    ctrl_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) uWaitTimer (
        .iClk     (iClk),
        .iRst     (iRst),
        .iClear   (stateD != stateQ),
        .iCountEn (waiting),
        .oExpired (expired)
    );

    // State register and sticky trap flags
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            stateQ   <= StFetch;
            illegalQ <= 1'b0;
            faultQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            if (illegalSet) illegalQ <= 1'b1;
            if (faultSet)   faultQ   <= 1'b1;
        end
    end

    // Next state and Moore decode (rdy-qualified write enables in memory states)
    always_comb begin
        stateD      = stateQ;
        illegalSet  = 1'b0;
        faultSet    = 1'b0;
        regWrite    = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        ioD         = 1'b0;
        irWrite     = 1'b0;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        retire      = 1'b0;
        aluSrcA     = SrcAPc;
        aluSrcB     = SrcBRegB;
        memtoReg    = MemtoRegAluOut;
        aluOp       = AluOpAdd;
        pcSource    = PcSrcAlu;

        unique case (stateQ)
            StFetch: begin
                aluSrcB = SrcBFour;
                memRead = 1'b1;
                irWrite = rdy;
                pcWrite = rdy;
                if (rdy) stateD = StDecode;
            end
            StDecode: begin
                // Speculative branch/jump target: ALUOut <= OldPC + imm
                aluSrcA = SrcAOldPc;
                aluSrcB = SrcBImm;
                case (opcode)
                    OpLoad, OpStore: stateD = StMemAddr;
                    OpR:             stateD = StExecR;
                    OpImm:           stateD = StExecI;
                    OpBranch:        stateD = StBranch;
                    OpJal:           stateD = StJal;
                    OpJalr:          stateD = StJalr;
                    OpLui:           stateD = (EN_UPPER != 0) ? StLui : StTrap;
                    OpAuipc:         stateD = (EN_UPPER != 0) ? StAuipc : StTrap;
                    default:         stateD = StTrap;
                endcase
                illegalSet = (stateD == StTrap);
            end
            StMemAddr: begin
                aluSrcA = SrcARegA;
                aluSrcB = SrcBImm;
                stateD  = (opcode == OpStore) ? StSwWr : StLwRd;
            end
            StLwRd: begin
                memRead = 1'b1;
                ioD     = 1'b1;
                if (rdy) stateD = StLwWb;
            end
            StLwWb: begin
                regWrite = 1'b1;
                memtoReg = MemtoRegMdr;
                retire   = 1'b1;
                stateD   = StFetch;
            end
            StSwWr: begin
                memWrite = 1'b1;
                ioD      = 1'b1;
                if (rdy) begin
                    retire = 1'b1;
                    stateD = StFetch;
                end
            end
            StExecR: begin
                aluSrcA = SrcARegA;
                aluSrcB = SrcBRegB;
                aluOp   = AluOpRFunct;
                stateD  = StAluWb;
            end
            StExecI: begin
                aluSrcA = SrcARegA;
                aluSrcB = SrcBImm;
                aluOp   = AluOpIFunct;
                stateD  = StAluWb;
            end
            StAluWb: begin
                regWrite = 1'b1;
                retire   = 1'b1;
                stateD   = StFetch;
            end
            StBranch: begin
                aluSrcA     = SrcARegA;
                aluSrcB     = SrcBRegB;
                aluOp       = AluOpBranch;
                pcWriteCond = 1'b1;
                pcSource    = PcSrcAluOut;
                retire      = 1'b1;
                stateD      = StFetch;
            end
            StJal: begin
                regWrite = 1'b1;
                memtoReg = MemtoRegLink;
                pcWrite  = 1'b1;
                pcSource = PcSrcAluOut;
                retire   = 1'b1;
                stateD   = StFetch;
            end
            StJalr: begin
                // Link captures PC before the same-edge PC update
                aluSrcA  = SrcARegA;
                aluSrcB  = SrcBImm;
                pcWrite  = 1'b1;
                pcSource = PcSrcAluClr0;
                regWrite = 1'b1;
                memtoReg = MemtoRegLink;
                retire   = 1'b1;
                stateD   = StFetch;
            end
            StLui: begin
                regWrite = 1'b1;
                memtoReg = MemtoRegImm;
                retire   = 1'b1;
                stateD   = StFetch;
            end
            StAuipc: begin
                regWrite = 1'b1;
                memtoReg = MemtoRegAluOut;
                retire   = 1'b1;
                stateD   = StFetch;
            end
            StTrap: begin
                stateD = StTrap;
            end
            default: begin
                stateD = StTrap;
            end
        endcase

        // Last allowed wait cycle without rdy: abandon the access
        if (expired) begin
            stateD   = StTrap;
            faultSet = 1'b1;
        end
    end

    // Reset forces every output low immediately, including an in-flight MemWrite
    always_comb begin
        oRegWrite    = regWrite & ~iRst;
        oMemRead     = memRead & ~iRst;
        oMemWrite    = memWrite & ~iRst;
        oIoD         = ioD & ~iRst;
        oIRWrite     = irWrite & ~iRst;
        oPCWrite     = pcWrite & ~iRst;
        oPCWriteCond = pcWriteCond & ~iRst;
        oRetire      = retire & ~iRst;
        oALUSrcA     = iRst ? 2'b00 : aluSrcA;
        oALUSrcB     = iRst ? 2'b00 : aluSrcB;
        oMemtoReg    = iRst ? 2'b00 : memtoReg;
        oALUOp       = iRst ? 2'b00 : aluOp;
        oPCSource    = iRst ? 2'b00 : pcSource;
        oIllegal     = illegalQ & ~iRst;
        oMemFault    = faultQ & ~iRst;
    end

endmodule

// File: tb/tb_controle_mc_param.sv
// Directed, table-driven bench for the multicycle controller.
module tb_controle_mc_param;

    typedef struct packed {
        logic       regWrite;
        logic [1:0] srcA;
        logic [1:0] srcB;
        logic       memRead;
        logic       memWrite;
        logic [1:0] memtoReg;
        logic       ioD;
        logic       irWrite;
        logic       pcWrite;
        logic       pcWriteCond;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
        logic       illegal;
        logic       memFault;
        logic       retire;
    } outT;

    typedef struct {
        string       name;
        logic        rst;
        logic [31:0] inst;
        logic        rdy;
        outT         exp;
    } vecT;

    localparam logic [31:0] IAdd   = 32'h002081B3;  // add  x3,x1,x2
    localparam logic [31:0] ILw    = 32'h0000A203;  // lw   x4,0(x1)
    localparam logic [31:0] ISw    = 32'h0020A023;  // sw   x2,0(x1)
    localparam logic [31:0] IAddi  = 32'h00108093;  // addi x1,x1,1
    localparam logic [31:0] IBeq   = 32'h00208463;  // beq  x1,x2,8
    localparam logic [31:0] IJal   = 32'h008000EF;  // jal  x1,8
    localparam logic [31:0] IJalr  = 32'h008280E7;  // jalr x1,8(x5)
    localparam logic [31:0] ILui   = 32'h000012B7;  // lui  x5,1
    localparam logic [31:0] IAuipc = 32'h00000297;  // auipc x5,0
    localparam logic [31:0] IBad   = 32'h0000007F;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic [31:0] iInst = IAdd;
    logic [31:0] iInst2 = ILui;
    logic        iMemReady = 1'b1;

    logic        regWrite, memRead, memWrite, ioD, irWrite, pcWrite, pcWriteCond;
    logic        illegal, memFault, retire;
    logic [1:0]  srcA, srcB, memtoReg, aluOp, pcSource;
    logic        regWrite2, memRead2, memWrite2, ioD2, irWrite2, pcWrite2, pcWriteCond2;
    logic        illegal2, memFault2, retire2;
    logic [1:0]  srcA2, srcB2, memtoReg2, aluOp2, pcSource2;
    outT         act, act2;

    int nVec = 0;
    int nFail = 0;
    vecT vecs[$];

    outT eZero, eFetch, eFetchWait, eDecode, eMemAddr, eLwRd, eLwWb, eSwWait, eSwDone;
    outT eExecR, eExecI, eAluWb, eBranch, eJal, eJalr, eLui, eAuipc, eTrapFault, eTrapIll;

    always #5 iClk = ~iClk;

    controle_mc_param #(
        .MEM_HANDSHAKE (1),
        .MEM_TIMEOUT   (4),
        .EN_UPPER      (1)
    ) dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .iInst        (iInst),
        .iMemReady    (iMemReady),
        .oRegWrite    (regWrite),
        .oALUSrcA     (srcA),
        .oALUSrcB     (srcB),
        .oMemRead     (memRead),
        .oMemWrite    (memWrite),
        .oMemtoReg    (memtoReg),
        .oIoD         (ioD),
        .oIRWrite     (irWrite),
        .oPCWrite     (pcWrite),
        .oPCWriteCond (pcWriteCond),
        .oALUOp       (aluOp),
        .oPCSource    (pcSource),
        .oIllegal     (illegal),
        .oMemFault    (memFault),
        .oRetire      (retire)
    );

    controle_mc_param #(
        .MEM_HANDSHAKE (1),
        .MEM_TIMEOUT   (4),
        .EN_UPPER      (0)
    ) dutNoUpper (
        .iClk         (iClk),
        .iRst         (iRst),
        .iInst        (iInst2),
        .iMemReady    (iMemReady),
        .oRegWrite    (regWrite2),
        .oALUSrcA     (srcA2),
        .oALUSrcB     (srcB2),
        .oMemRead     (memRead2),
        .oMemWrite    (memWrite2),
        .oMemtoReg    (memtoReg2),
        .oIoD         (ioD2),
        .oIRWrite     (irWrite2),
        .oPCWrite     (pcWrite2),
        .oPCWriteCond (pcWriteCond2),
        .oALUOp       (aluOp2),
        .oPCSource    (pcSource2),
        .oIllegal     (illegal2),
        .oMemFault    (memFault2),
        .oRetire      (retire2)
    );

    assign act  = {regWrite, srcA, srcB, memRead, memWrite, memtoReg, ioD, irWrite, pcWrite,
                   pcWriteCond, aluOp, pcSource, illegal, memFault, retire};
    assign act2 = {regWrite2, srcA2, srcB2, memRead2, memWrite2, memtoReg2, ioD2, irWrite2,
                   pcWrite2, pcWriteCond2, aluOp2, pcSource2, illegal2, memFault2, retire2};

    task automatic check(input string n, input outT a, input outT e);
        nVec++;
        if (a !== e) begin
            nFail++;
            $display("FAIL %s: got %05h expected %05h", n, a, e);
        end
    endtask

    // Drive one cycle's inputs away from the edge and check the Moore outputs
    task automatic step(input string n, input logic r, input logic [31:0] i, input logic y,
                        input outT e);
        @(negedge iClk);
        iRst = r;
        iInst = i;
        iMemReady = y;
        #1;
        check(n, act, e);
    endtask

    task automatic addV(input string n, input logic r, input logic [31:0] i, input logic y,
                        input outT e);
        vecT v;
        v.name = n;
        v.rst = r;
        v.inst = i;
        v.rdy = y;
        v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        eZero = '0;
        eFetchWait = '0; eFetchWait.srcB = 2'b01; eFetchWait.memRead = 1'b1;
        eFetch = eFetchWait; eFetch.irWrite = 1'b1; eFetch.pcWrite = 1'b1;
        eDecode = '0; eDecode.srcA = 2'b10; eDecode.srcB = 2'b10;
        eMemAddr = '0; eMemAddr.srcA = 2'b01; eMemAddr.srcB = 2'b10;
        eLwRd = '0; eLwRd.memRead = 1'b1; eLwRd.ioD = 1'b1;
        eLwWb = '0; eLwWb.regWrite = 1'b1; eLwWb.memtoReg = 2'b01; eLwWb.retire = 1'b1;
        eSwWait = '0; eSwWait.memWrite = 1'b1; eSwWait.ioD = 1'b1;
        eSwDone = eSwWait; eSwDone.retire = 1'b1;
        eExecR = '0; eExecR.srcA = 2'b01; eExecR.aluOp = 2'b10;
        eExecI = '0; eExecI.srcA = 2'b01; eExecI.srcB = 2'b10; eExecI.aluOp = 2'b11;
        eAluWb = '0; eAluWb.regWrite = 1'b1; eAluWb.retire = 1'b1;
        eBranch = '0; eBranch.srcA = 2'b01; eBranch.aluOp = 2'b01; eBranch.pcWriteCond = 1'b1;
        eBranch.pcSource = 2'b01; eBranch.retire = 1'b1;
        eJal = '0; eJal.regWrite = 1'b1; eJal.memtoReg = 2'b10; eJal.pcWrite = 1'b1;
        eJal.pcSource = 2'b01; eJal.retire = 1'b1;
        eJalr = '0; eJalr.srcA = 2'b01; eJalr.srcB = 2'b10; eJalr.pcWrite = 1'b1;
        eJalr.pcSource = 2'b10; eJalr.regWrite = 1'b1; eJalr.memtoReg = 2'b10;
        eJalr.retire = 1'b1;
        eLui = '0; eLui.regWrite = 1'b1; eLui.memtoReg = 2'b11; eLui.retire = 1'b1;
        eAuipc = '0; eAuipc.regWrite = 1'b1; eAuipc.retire = 1'b1;
        eTrapFault = '0; eTrapFault.memFault = 1'b1;
        eTrapIll = '0; eTrapIll.illegal = 1'b1;

        addV("reset",        1, IAdd, 1, eZero);
        addV("add fetch",    0, IAdd, 1, eFetch);
        addV("add decode",   0, IAdd, 1, eDecode);
        addV("add execR",    0, IAdd, 1, eExecR);
        addV("add wb",       0, IAdd, 1, eAluWb);
        addV("lw fetch",     0, ILw, 1, eFetch);
        addV("lw decode",    0, ILw, 1, eDecode);
        addV("lw memaddr",   0, ILw, 1, eMemAddr);
        addV("lw wait1",     0, ILw, 0, eLwRd);
        addV("lw wait2",     0, ILw, 0, eLwRd);
        addV("lw wait3",     0, ILw, 0, eLwRd);
        addV("lw rdy",       0, ILw, 1, eLwRd);
        addV("lw wb",        0, ILw, 1, eLwWb);
        addV("addi fetch",   0, IAddi, 1, eFetch);
        addV("addi decode",  0, IAddi, 1, eDecode);
        addV("addi execI",   0, IAddi, 1, eExecI);
        addV("addi wb",      0, IAddi, 1, eAluWb);
        addV("beq fetch",    0, IBeq, 1, eFetch);
        addV("beq decode",   0, IBeq, 1, eDecode);
        addV("beq branch",   0, IBeq, 1, eBranch);
        addV("jal fetch",    0, IJal, 1, eFetch);
        addV("jal decode",   0, IJal, 1, eDecode);
        addV("jal jal",      0, IJal, 1, eJal);
        addV("jalr fetch",   0, IJalr, 1, eFetch);
        addV("jalr decode",  0, IJalr, 1, eDecode);
        addV("jalr jalr",    0, IJalr, 1, eJalr);
        addV("lui fetch",    0, ILui, 1, eFetch);
        addV("lui decode",   0, ILui, 1, eDecode);
        addV("lui lui",      0, ILui, 1, eLui);
        addV("auipc fetch",  0, IAuipc, 1, eFetch);
        addV("auipc decode", 0, IAuipc, 1, eDecode);
        addV("auipc auipc",  0, IAuipc, 1, eAuipc);
        addV("fetch wait1",  0, IAdd, 0, eFetchWait);
        addV("fetch wait2",  0, IAdd, 0, eFetchWait);
        addV("fetch rdy",    0, IAdd, 1, eFetch);
        addV("add2 decode",  0, IAdd, 1, eDecode);
        addV("add2 execR",   0, IAdd, 1, eExecR);
        addV("add2 wb",      0, IAdd, 1, eAluWb);
        addV("sw fetch",     0, ISw, 1, eFetch);
        addV("sw decode",    0, ISw, 1, eDecode);
        addV("sw memaddr",   0, ISw, 1, eMemAddr);
        addV("sw wait",      0, ISw, 0, eSwWait);
        addV("sw done",      0, ISw, 1, eSwDone);
        addV("swto fetch",   0, ISw, 1, eFetch);
        addV("swto decode",  0, ISw, 1, eDecode);
        addV("swto memaddr", 0, ISw, 1, eMemAddr);
        addV("swto wait1",   0, ISw, 0, eSwWait);
        addV("swto wait2",   0, ISw, 0, eSwWait);
        addV("swto wait3",   0, ISw, 0, eSwWait);
        addV("swto wait4",   0, ISw, 0, eSwWait);
        addV("swto trap",    0, ISw, 0, eTrapFault);
        addV("swto trap rdy", 0, ISw, 1, eTrapFault);
        addV("reset2",       1, IBad, 1, eZero);
        addV("bad fetch",    0, IBad, 1, eFetch);
        addV("bad decode",   0, IBad, 1, eDecode);
        addV("bad trap1",    0, IBad, 1, eTrapIll);
        addV("bad trap2",    0, IBad, 0, eTrapIll);
        addV("reset3",       1, IAdd, 0, eZero);
        addV("fto wait1",    0, IAdd, 0, eFetchWait);
        addV("fto wait2",    0, IAdd, 0, eFetchWait);
        addV("fto wait3",    0, IAdd, 0, eFetchWait);
        addV("fto wait4",    0, IAdd, 0, eFetchWait);
        addV("fto trap",     0, IAdd, 1, eTrapFault);
        addV("reset4",       1, ISw, 1, eZero);

        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].name, vecs[k].rst, vecs[k].inst, vecs[k].rdy, vecs[k].exp);
        end

        // Reset pulse while a store is stalled: MemWrite must drop without a clock edge
        step("rst sw fetch",   0, ISw, 1, eFetch);
        step("rst sw decode",  0, ISw, 1, eDecode);
        step("rst sw memaddr", 0, ISw, 1, eMemAddr);
        step("rst sw wait1",   0, ISw, 0, eSwWait);
        step("rst sw wait2",   0, ISw, 0, eSwWait);
        @(posedge iClk);
        #2;
        iRst = 1'b1;
        #1;
        check("async rst", act, eZero);
        // After release the full timeout budget is available again
        step("post rst fetch", 0, ISw, 0, eFetchWait);
        step("post fetch rdy", 0, ISw, 1, eFetch);
        step("post decode",    0, ISw, 1, eDecode);
        step("post memaddr",   0, ISw, 1, eMemAddr);
        step("post wait1",     0, ISw, 0, eSwWait);
        step("post wait2",     0, ISw, 0, eSwWait);
        step("post wait3",     0, ISw, 0, eSwWait);
        step("post rdy limit", 0, ISw, 1, eSwDone);
        step("post next fetch", 0, IAdd, 1, eFetch);

        // LUI on a build without upper-immediate support
        @(negedge iClk);
        iRst = 1'b1;
        iMemReady = 1'b1;
        #1;
        check("noupper reset", act2, eZero);
        @(negedge iClk);
        iRst = 1'b0;
        #1;
        check("noupper fetch", act2, eFetch);
        @(negedge iClk);
        #1;
        check("noupper decode", act2, eDecode);
        @(negedge iClk);
        #1;
        check("noupper trap1", act2, eTrapIll);
        @(negedge iClk);
        #1;
        check("noupper trap2", act2, eTrapIll);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
